// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared types and constants for the reference DAC serial write engine
//
// Purpose: frame state encoding, default frame width, interval counter width and
// the idle/reset levels of the DAC pins.
// Ports: none (package).
package dac_pkg;

  // Default frame length in bits (width of the DAC word).
  localparam int DATA_W_DEF = 16;

  // Width of the interval counter; HALF and GAP must each fit in 1..255.
  localparam int CNT_W = 8;

  // Pin levels while in reset or idle: frame deselected, clock parked high.
  localparam logic SYNC_RST = 1'b1;
  localparam logic SCLK_RST = 1'b1;
  localparam logic SDI_RST  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

endpackage

// File: rtl/dac_tick_gen.sv
// rtl/dac_tick_gen.sv - loadable down-counter that flags the last cycle of an interval
//
// Purpose: times the SETUP/LOW/HIGH half-periods and the post-frame GAP.
// Loading N-1 on a state entry makes tick rise on the N-th cycle of that state.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   load     in   reload the counter this cycle
//   load_val in   interval length minus one
//   tick     out  high on the final cycle of the current interval
module dac_tick_gen
  import dac_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at zero so an unreloaded counter just keeps reporting expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/dac_serial_ctrl.sv
// rtl/dac_serial_ctrl.sv - serial write engine for the 16-bit reference DAC (SYNC/SCLK/SDI)
//
// Purpose: on a rising edge of ctrl while idle, latch dato and shift it out
// MSB-first in one SYNC-low frame, SCLK = clk / (2*HALF), then hold SYNC high
// for GAP cycles before accepting another start.
// Ports:
//   clk    in   50 MHz system clock
//   rst_n  in   asynchronous active-low reset
//   ctrl   in   start request, acted on at its rising edge
//   dato   in   word to send, sampled on the accepted start edge
//   sync   out  DAC frame select, active low
//   sdi    out  serial data, valid around the SCLK falling edge
//   sclk   out  serial clock, idles high
//   busy   out  frame or gap in progress
//   done   out  one-cycle pulse on the last gap cycle
module dac_serial_ctrl
  import dac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int HALF   = 2,
  parameter int GAP    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl,
  input  logic [DATA_W-1:0] dato,
  output logic              sync,
  output logic              sdi,
  output logic              sclk,
  output logic              busy,
  output logic              done
);

  localparam int               BIT_W   = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              ctrl_q, ctrl_d;
  logic              arm_q, arm_d;
  logic              sync_q, sync_d;
  logic              sclk_q, sclk_d;
  logic              sdi_q, sdi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              start;
  logic              in_frame;
  logic              tick;
  logic              load;
  logic [CNT_W-1:0]  load_val;

  dac_tick_gen u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .tick     (tick)
  );

  // arm_q keeps the first cycle after reset from seeing a fake edge against
  // the cleared history, so a ctrl already high at release starts nothing.
  // busy_q covers the one cycle where the FSM is back in IDLE but the pins
  // still show the final gap cycle; an edge there is dropped, not queued.
  assign start = ctrl && !ctrl_q && arm_q && !busy_q;

  // Next-state and datapath.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bit_d    = bit_q;
    ctrl_d   = ctrl;
    arm_d    = 1'b1;
    load     = 1'b0;
    load_val = HALF_M1;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          sr_d    = dato;
          bit_d   = BIT_W'(DATA_W - 1);
          load    = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_LOW;
          load    = 1'b1;
        end
      end
      ST_LOW: begin
        if (tick) begin
          state_d = ST_HIGH;
          load    = 1'b1;
          // Shift together with the HIGH entry so the next bit appears on
          // the pin alongside the SCLK rising edge; the last bit is held.
          if (bit_q != '0) begin
            sr_d = {sr_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      ST_HIGH: begin
        if (tick) begin
          load = 1'b1;
          if (bit_q == '0) begin
            state_d  = ST_GAP;
            load_val = GAP_M1;
          end else begin
            state_d = ST_LOW;
            bit_d   = bit_q - BIT_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin values are decoded from the current state and registered, so each
  // pin trails the state register by one cycle and never glitches.
  always_comb begin
    in_frame = (state_q == ST_SETUP) || (state_q == ST_LOW) || (state_q == ST_HIGH);
    sync_d   = in_frame ? 1'b0 : SYNC_RST;
    sclk_d   = (state_q == ST_LOW) ? 1'b0 : SCLK_RST;
    sdi_d    = in_frame ? sr_q[DATA_W-1] : SDI_RST;
    busy_d   = (state_q != ST_IDLE);
    done_d   = (state_q == ST_GAP) && tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      ctrl_q  <= 1'b0;
      arm_q   <= 1'b0;
      sync_q  <= SYNC_RST;
      sclk_q  <= SCLK_RST;
      sdi_q   <= SDI_RST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      ctrl_q  <= ctrl_d;
      arm_q   <= arm_d;
      sync_q  <= sync_d;
      sclk_q  <= sclk_d;
      sdi_q   <= sdi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sync = sync_q;
  assign sclk = sclk_q;
  assign sdi  = sdi_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_dac_serial_ctrl.sv
// tb/tb_dac_serial_ctrl.sv - self-checking bench for dac_serial_ctrl
module tb_dac_serial_ctrl;

  localparam int DATA_W    = 16;
  localparam int HALF      = 2;
  localparam int GAP       = 4;
  localparam int FRAME_LOW = HALF + 2 * HALF * DATA_W;
  // Cycle 0 is the cycle in which ctrl rises; cycle k is sampled on the
  // falling clk edge after the k-th rising edge.
  localparam int FIRST_LOW = 2;
  localparam int DONE_CYC  = GAP + FRAME_LOW + 1;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              ctrl  = 1'b0;
  logic [DATA_W-1:0] dato  = '0;
  logic              sync, sdi, sclk, busy, done;

  int checks = 0;
  int errors = 0;

  dac_serial_ctrl #(.DATA_W(DATA_W), .HALF(HALF), .GAP(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (ctrl),
    .dato  (dato),
    .sync  (sync),
    .sdi   (sdi),
    .sclk  (sclk),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Reference: number of sdi transitions inside a frame is the number of
  // neighbouring bit pairs of the word that differ.
  function automatic int bit_changes(input logic [DATA_W-1:0] w);
    int n = 0;
    for (int i = 0; i < DATA_W - 1; i++) begin
      if (w[i] != w[i+1]) n++;
    end
    return n;
  endfunction

  // Starts a frame, watches the pins for a fixed window and compares what a
  // DAC would see against the reference word and frame timing.
  task automatic run_frame(input string tag, input logic [DATA_W-1:0] word, input int hold,
                           input int p2_cyc, input logic [DATA_W-1:0] dato2,
                           input logic [DATA_W-1:0] exp_word);
    int ncyc = (hold > 100 ? hold : 0) + 110;
    logic [DATA_W-1:0] got = '0;
    int   falls = 0, low = 0, first_low = 0, done_cnt = 0, done_cyc = 0;
    int   bad_per = 0, sdi_chg = 0, last_fall = 0;
    logic prev_sclk = 1'b1, prev_sdi = 1'b0, prev_sync = 1'b1;
    @(negedge clk);
    dato = word;
    ctrl = 1'b1;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      if (!sync) begin
        low++;
        if (first_low == 0) first_low = cyc;
        if (!prev_sync && sdi !== prev_sdi) sdi_chg++;
      end
      if (prev_sclk && !sclk) begin
        if (!sync) got = {got[DATA_W-2:0], sdi};
        falls++;
        if (last_fall != 0 && cyc - last_fall != 2 * HALF) bad_per++;
        last_fall = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_sclk = sclk;
      prev_sdi  = sdi;
      prev_sync = sync;
      if (cyc == hold) ctrl = 1'b0;
      if (p2_cyc != 0 && cyc == p2_cyc) begin
        dato = dato2;
        ctrl = 1'b1;
      end
      if (p2_cyc != 0 && cyc == p2_cyc + 2) ctrl = 1'b0;
    end
    check({tag, " word"},        int'(got), int'(exp_word));
    check({tag, " falls"},       falls, DATA_W);
    check({tag, " sync_low"},    low, FRAME_LOW);
    check({tag, " first_low"},   first_low, FIRST_LOW);
    check({tag, " done_cnt"},    done_cnt, 1);
    check({tag, " done_cyc"},    done_cyc, DONE_CYC);
    check({tag, " sclk_period"}, bad_per, 0);
    check({tag, " sdi_changes"}, sdi_chg, bit_changes(exp_word));
    check({tag, " idle_after"},  int'({sync, sclk, sdi, busy}), int'(4'b1100));
  endtask

  typedef struct {
    string             tag;
    logic [DATA_W-1:0] dato;
    int                hold;
    int                p2_cyc;
    logic [DATA_W-1:0] dato2;
    logic [DATA_W-1:0] exp_word;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int bad;
    int lows;
    int dones;

    vecs[0] = '{"a5c3",     16'hA5C3, 3,   0,  16'h0000, 16'hA5C3};
    vecs[1] = '{"zeros",    16'h0000, 3,   0,  16'h0000, 16'h0000};
    vecs[2] = '{"ones",     16'hFFFF, 3,   0,  16'h0000, 16'hFFFF};
    vecs[3] = '{"held500",  16'h8001, 500, 0,  16'h0000, 16'h8001};
    vecs[4] = '{"ignore2",  16'hA5C3, 3,   20, 16'h1234, 16'hA5C3};
    vecs[5] = '{"after2",   16'h1234, 3,   0,  16'h0000, 16'h1234};

    // Reset held with ctrl toggling: pins stay idle.
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sync !== 1'b1 || sclk !== 1'b1 || sdi !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
      ctrl = ~ctrl;
    end
    check("reset_idle", bad, 0);

    // Release with ctrl already high: no frame.
    ctrl = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sync !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("release_ctrl_high", lows, 0);
    ctrl = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].tag, vecs[v].dato, vecs[v].hold, vecs[v].p2_cyc,
                vecs[v].dato2, vecs[v].exp_word);
    end

    // Reset pulsed mid-frame.
    @(negedge clk);
    dato = 16'hFFFF;
    ctrl = 1'b1;
    repeat (3) @(negedge clk);
    ctrl = 1'b0;
    repeat (27) @(negedge clk);
    check("mid_active", int'(sync), 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pins", int'({sync, sclk, sdi, busy}), int'(4'b1100));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows  = 0;
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sync !== 1'b1) lows++;
      if (done !== 1'b0) dones++;
    end
    check("post_rst_idle", lows, 0);
    check("post_rst_done", dones, 0);

    // Random words against the reference frame rules.
    for (int r = 0; r < 16; r++) begin
      logic [DATA_W-1:0] w;
      w = DATA_W'($urandom);
      run_frame("rand", w, int'($urandom_range(1, 5)), 0, '0, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_serial_ctrl.md
Name: dac_serial_ctrl

Overview:
- Serial write engine for the board's 16-bit reference DAC. It drives SYNC, SCLK and SDI.
- On a start request from the global control block, it captures a 16-bit word and shifts it out MSB-first in one SYNC-low frame.
- It runs on the 50 MHz system clock and generates SCLK internally by division.
- It sits between the command decoder (source of the ctrl/dato pair) and the DAC pins (CS_DAC, SDI_DAC, CLK_DAC).

Parameters:
- DATA_W, 16, frame length in bits. Also the width of dato and the shift register.
- HALF, 2, system-clock cycles per SCLK half-period. With the 50 MHz clock this gives a 12.5 MHz SCLK. Legal range 1..255.
- GAP, 4, system-clock cycles SYNC is held high after a frame before a new start is accepted.

Ports:
- clk  in  1  system clock, 50 MHz, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- ctrl  in  1  start request. Level input; the block acts only on its rising edge.
- dato  in  DATA_W  word to transmit. Sampled only on the accepted start edge.
- sync  out  1  DAC frame select, active low (CS_DAC).
- sdi  out  1  serial data to the DAC.
- sclk  out  1  serial clock to the DAC. Idles high; the DAC samples sdi on the falling edge.
- busy  out  1  high from an accepted start until the end of the GAP period.
- done  out  1  one-cycle pulse on the last GAP cycle.

Behaviour:
- Reset state, asynchronous, while rst_n is low: sync=1, sclk=1, sdi=0, busy=0, done=0. State is IDLE, the shift register is 0, and the ctrl edge-detector history register is 0.
- Start detection:
  - ctrl is registered once. A start is the condition ctrl=1 and ctrl_q=0, evaluated in IDLE only.
  - A rising edge while busy is ignored. It is not queued.
  - ctrl held high produces exactly one frame.
- State machine: IDLE -> SETUP -> (LOW <-> HIGH) x DATA_W -> GAP -> IDLE.
- IDLE:
  - Outputs sync=1, sclk=1, sdi=0.
  - On start: load dato into the shift register, set busy=1, go to SETUP.
- SETUP (HALF cycles):
  - sync=0, sclk=1, sdi = bit DATA_W-1 of the latched word.
  - Both sync and sdi become valid in the first SETUP cycle, i.e. one cycle after the start edge is sampled.
- LOW (HALF cycles):
  - sclk=0. The DAC samples sdi on entry to this state.
  - sdi stays stable.
- HIGH (HALF cycles):
  - sclk=1.
  - On entry, if bits remain, sdi advances to the next lower bit.
  - After the HIGH that follows the DATA_W-th LOW, go to GAP.
- GAP (GAP cycles):
  - sync=1, sclk=1, sdi=0, busy=1.
  - done=1 on the final GAP cycle, then return to IDLE with busy=0.
- Timing figures:
  - sync is low for exactly HALF + 2*HALF*DATA_W cycles (66 cycles at default values).
  - Exactly DATA_W falling edges of sclk occur per frame.
  - The bit counter counts DATA_W-1 down to 0 and never wraps within a frame.
  - Data order is MSB-first.
- Input stability: changes to dato after the start edge do not affect the frame in progress.
- Reset mid-frame: outputs return to idle values immediately (asynchronously). No partial frame resumes after rst_n is released.
- Registered outputs: all outputs come from registers, so no combinational glitches reach the pins.

Decomposition:
- Shared package dac_pkg:
  - state enum {IDLE, SETUP, LOW, HIGH, GAP}
  - DATA_W default
  - reset-value constants for sync, sclk and sdi
- One sub-module, dac_tick_gen: loadable down-counter that asserts a one-cycle tick when a HALF or GAP interval expires. The FSM and shift register remain in dac_serial_ctrl.

Test Plan:
- Reset check: hold rst_n=0 with ctrl toggling -> sync=1, sclk=1, sdi=0, busy=0 throughout. Release reset with ctrl already high -> no frame starts until ctrl falls and rises again.
- Single write: dato=16'hA5C3, ctrl pulse -> the bits captured on the 16 sclk falling edges equal A5C3 MSB-first. sync is low for 66 cycles; done pulses once, GAP+66+1 cycles after the start edge sample.
- Extremes: dato=16'h0000, then 16'hFFFF -> sdi is constant within each frame, exactly 16 falling edges, and sclk period is 4 clk cycles.
- ctrl held high for 500 cycles -> exactly one frame and one done pulse.
- Second ctrl edge at cycle 20 of a frame, with dato changed to 16'h1234 -> it is ignored and the frame still carries the original word. A new edge after done -> frame carries 16'h1234.
- rst_n pulsed low at cycle 30 of a frame -> sync=1 and sclk=1 in the same cycle. After release, the block stays idle until a new ctrl edge.
